branch_redirect_controller: RTL and testbench
=============================================

BRANCH_REDIRECT_CONTROLLER -- requirements
Module: branch_redirect_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of the taken-redirect statistics counter.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 SHALL have port BRANCH_TAKEN  input  1  taken decision from the EX-stage branch comparator (branch or jump).
REQ-005 SHALL have port BRANCH_TARGET  input  32  EX-stage computed target address.
REQ-006 SHALL have port EX_VALID  input  1  EX stage holds a valid (non-bubble) instruction.
REQ-007 SHALL have port PIPE_STALL  input  1  global pipeline stall (e.g. data memory busy); freezes all stages.
REQ-008 SHALL have port IMEM_BUSY  input  1  instruction memory cannot accept a new fetch address this cycle.
REQ-009 SHALL have port PC_SEL  output  1  1 = PC loads PC_TARGET instead of PC+4.
REQ-010 SHALL have port PC_TARGET  output  32  registered redirect address.
REQ-011 SHALL have port FLUSH_IF_ID  output  1  convert IF/ID register contents to a bubble.
REQ-012 SHALL have port FLUSH_ID_EX  output  1  convert ID/EX register contents to a bubble.
REQ-013 SHALL have port REDIRECT_BUSY  output  1  redirect in progress (state != IDLE).
REQ-014 SHALL have port TAKEN_COUNT  output  CNT_W  number of accepted redirects, saturating.

Function
REQ-015 SHALL implement FSM states IDLE, REDIRECT, WAIT_IMEM.
REQ-016 In IDLE, capture occurs at a rising edge iff BRANCH_TAKEN=1, EX_VALID=1, PIPE_STALL=0: PC_TARGET <= BRANCH_TARGET, state <= REDIRECT, TAKEN_COUNT increments.
REQ-017 In IDLE, all control outputs SHALL be 0; BRANCH_TAKEN with EX_VALID=0 or PIPE_STALL=1 SHALL be ignored that cycle.
REQ-018 In REDIRECT and WAIT_IMEM, PC_SEL=1, FLUSH_IF_ID=1, FLUSH_ID_EX=1, REDIRECT_BUSY=1, PC_TARGET held stable.
REQ-019 REDIRECT: if IMEM_BUSY=0 and PIPE_STALL=0 at the edge, redirect is accepted, state <= IDLE; if IMEM_BUSY=1, state <= WAIT_IMEM.
REQ-020 WAIT_IMEM: remain until an edge with IMEM_BUSY=0 and PIPE_STALL=0, then state <= IDLE.
REQ-021 PIPE_STALL=1 SHALL freeze state, PC_TARGET and TAKEN_COUNT; outputs hold their current values.
REQ-022 BRANCH_TAKEN while REDIRECT_BUSY=1 SHALL be ignored (wrong-path instruction being flushed); no capture, no count.
REQ-023 Latency: capture edge N -> PC_SEL high during cycle N+1; minimum redirect duration 1 cycle; maximum unbounded while IMEM_BUSY/PIPE_STALL held.
REQ-024 Back-to-back: a taken branch in EX in the cycle immediately after return to IDLE SHALL be captured normally.
REQ-025 TAKEN_COUNT SHALL saturate at all-ones (2^CNT_W-1); no wrap-around.
REQ-026 PC_TARGET SHALL be passed unmodified, full 32 bits; no alignment masking in this block.

Reset
REQ-027 RESET=0 SHALL immediately (asynchronously) force state IDLE, PC_TARGET=0, TAKEN_COUNT=0, PC_SEL=FLUSH_IF_ID=FLUSH_ID_EX=REDIRECT_BUSY=0.
REQ-028 Reset asserted mid-redirect SHALL abandon the redirect; no pending redirect survives reset deassertion.
REQ-029 First capture possible at the first rising edge after RESET returns to 1.

Structure
REQ-030 FSM state encodings and CNT_W default SHALL live in the shared pipeline definitions header/package, reused by the hazard unit.
REQ-031 Saturating counter SHALL be a sub-module named sat_counter (parameter width, inputs CLK, RESET, EN; output COUNT).
REQ-032 FSM next-state and output decode SHALL be in this module; outputs decoded from state only (Moore).

Verification
REQ-033 Reset then BRANCH_TAKEN=1, EX_VALID=1, BRANCH_TARGET=0x0000_0100, IMEM_BUSY=0 for one cycle -> next cycle PC_SEL=1, PC_TARGET=0x100, both flushes 1; following cycle IDLE, TAKEN_COUNT=1.
REQ-034 Capture target 0x0000_2000, IMEM_BUSY=1 for 3 cycles -> PC_SEL/flushes held 4 cycles, PC_TARGET=0x2000 throughout, IDLE after IMEM_BUSY falls.
REQ-035 BRANCH_TAKEN=1 with EX_VALID=0, and separately with PIPE_STALL=1 -> no capture, TAKEN_COUNT unchanged, outputs 0.
REQ-036 During REDIRECT assert BRANCH_TAKEN with target 0xDEAD_BEEC -> PC_TARGET keeps original value, count not incremented.
REQ-037 RESET=0 pulsed mid-WAIT_IMEM -> all outputs 0 without a clock edge, IDLE after release.
REQ-038 CNT_W=4, 17 accepted redirects -> TAKEN_COUNT=0xF.

Source files
------------

// File: rtl/branch_redirect_controller_pkg.sv
// Shared pipeline definitions: redirect FSM encodings and the default
// width of the taken-redirect statistics counter. The hazard unit imports
// the same package so both blocks agree on state values.
package branch_redirect_controller_pkg;

    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REDIRECT  = 2'd1,
        ST_WAIT_IMEM = 2'd2
    } redirect_state_e;

    // True whenever a redirect is in flight and the front end must be steered.
    function automatic logic is_redirecting(input redirect_state_e st);
        return (st == ST_REDIRECT) || (st == ST_WAIT_IMEM);
    endfunction

endpackage

// File: rtl/branch_redirect_controller_sat_counter.sv
// Saturating up-counter: increments on EN, sticks at all-ones, never wraps.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    output logic [WIDTH-1:0] COUNT
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Count enabled events until every bit is set, then hold.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            COUNT <= '0;
        end else if (EN && !(&COUNT)) begin
            COUNT <= COUNT + ONE;
        end
    end

endmodule

// File: rtl/branch_redirect_controller.sv
// Branch redirect controller: captures a taken EX-stage branch, steers the
// PC to the captured target and flushes IF/ID and ID/EX until the
// instruction memory accepts the new fetch address.
//
// Redirect handshake: while a redirect is in flight the block holds
// PC_SEL=1 and PC_TARGET stable (the "valid" side). The fetch side accepts
// the redirect on a rising edge where IMEM_BUSY=0 and PIPE_STALL=0 (the
// "ready" side); the transfer happens on exactly that edge and the FSM
// returns to IDLE. Nothing is dropped or altered while waiting.
module branch_redirect_controller
    import branch_redirect_controller_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             BRANCH_TAKEN,
    input  logic [31:0]      BRANCH_TARGET,
    input  logic             EX_VALID,
    input  logic             PIPE_STALL,
    input  logic             IMEM_BUSY,
    output logic             PC_SEL,
    output logic [31:0]      PC_TARGET,
    output logic             FLUSH_IF_ID,
    output logic             FLUSH_ID_EX,
    output logic             REDIRECT_BUSY,
    output logic [CNT_W-1:0] TAKEN_COUNT,
    output redirect_state_e  dbg_state
);

    redirect_state_e state;
    redirect_state_e state_next;
    logic            capture;
    logic            redirect_accept;

    // A branch is only taken up when idle; while busy the instruction in EX
    // is on the wrong path and is being flushed, so it is ignored.
    assign capture         = (state == ST_IDLE) && BRANCH_TAKEN && EX_VALID && !PIPE_STALL;
    assign redirect_accept = !IMEM_BUSY && !PIPE_STALL;

    // State register; a global stall freezes it in place.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else if (!PIPE_STALL) begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (capture) begin
                    state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (redirect_accept) begin
                    state_next = ST_IDLE;
                end else if (IMEM_BUSY) begin
                    state_next = ST_WAIT_IMEM;
                end
            end
            ST_WAIT_IMEM: begin
                if (redirect_accept) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Moore outputs: every control line follows the state alone.
    always_comb begin
        PC_SEL        = 1'b0;
        FLUSH_IF_ID   = 1'b0;
        FLUSH_ID_EX   = 1'b0;
        REDIRECT_BUSY = 1'b0;
        if (is_redirecting(state)) begin
            PC_SEL        = 1'b1;
            FLUSH_IF_ID   = 1'b1;
            FLUSH_ID_EX   = 1'b1;
            REDIRECT_BUSY = 1'b1;
        end
    end

    // Target register: loaded only on capture, so it stays put for the
    // whole redirect; the full 32-bit address passes through unmasked.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            PC_TARGET <= 32'h0;
        end else if (capture) begin
            PC_TARGET <= BRANCH_TARGET;
        end
    end

    assign dbg_state = state;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_taken_counter (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (capture),
        .COUNT (TAKEN_COUNT)
    );

endmodule

// File: tb/tb_branch_redirect_controller.sv
// Bench for branch_redirect_controller: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model that
// only knows "a redirect is pending or not", its target and a capped count.
module tb_branch_redirect_controller;
    import branch_redirect_controller_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int EXP_W   = 1 + 32 + CNT_W;

    logic             CLK;
    logic             RESET;
    logic             BRANCH_TAKEN;
    logic [31:0]      BRANCH_TARGET;
    logic             EX_VALID;
    logic             PIPE_STALL;
    logic             IMEM_BUSY;
    logic             PC_SEL;
    logic [31:0]      PC_TARGET;
    logic             FLUSH_IF_ID;
    logic             FLUSH_ID_EX;
    logic             REDIRECT_BUSY;
    logic [CNT_W-1:0] TAKEN_COUNT;
    redirect_state_e  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit          m_busy;
    logic [31:0] m_target;
    int          m_count;

    logic [EXP_W-1:0] exp_q[$];

    branch_redirect_controller #(.CNT_W(CNT_W)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .EX_VALID      (EX_VALID),
        .PIPE_STALL    (PIPE_STALL),
        .IMEM_BUSY     (IMEM_BUSY),
        .PC_SEL        (PC_SEL),
        .PC_TARGET     (PC_TARGET),
        .FLUSH_IF_ID   (FLUSH_IF_ID),
        .FLUSH_ID_EX   (FLUSH_ID_EX),
        .REDIRECT_BUSY (REDIRECT_BUSY),
        .TAKEN_COUNT   (TAKEN_COUNT),
        .dbg_state     (dbg_state)
    );

    // Clock / reset block.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_target = 32'h0;
        m_count  = 0;
    endtask

    // One clock of behaviour: a pending redirect clears when the fetch side
    // can take it; otherwise a valid taken branch starts a new one.
    task automatic model_edge(input logic tk, input logic vld, input logic stl,
                              input logic ib, input logic [31:0] tgt);
        if (stl) return;
        if (m_busy) begin
            if (!ib) m_busy = 1'b0;
        end else if (tk && vld) begin
            m_busy   = 1'b1;
            m_target = tgt;
            if (m_count < CNT_MAX) m_count++;
        end
    endtask

    // Compare all outputs against a packed expectation.
    task automatic compare_outputs(input logic [EXP_W-1:0] e, input string tag);
        logic           e_busy;
        logic [31:0]    e_tgt;
        logic [CNT_W-1:0] e_cnt;
        {e_busy, e_tgt, e_cnt} = e;
        check({tag, ".pc_sel"},   32'(PC_SEL),        32'(e_busy));
        check({tag, ".flush_if"}, 32'(FLUSH_IF_ID),   32'(e_busy));
        check({tag, ".flush_ex"}, 32'(FLUSH_ID_EX),   32'(e_busy));
        check({tag, ".busy"},     32'(REDIRECT_BUSY), 32'(e_busy));
        check({tag, ".target"},   PC_TARGET,          e_tgt);
        check({tag, ".count"},    32'(TAKEN_COUNT),   32'(e_cnt));
    endtask

    // Driver: apply inputs, clock once, update model, check #1 after the edge.
    task automatic step(input logic tk, input logic vld, input logic stl,
                        input logic ib, input logic [31:0] tgt, input string tag);
        logic [EXP_W-1:0] e;
        BRANCH_TAKEN  = tk;
        EX_VALID      = vld;
        PIPE_STALL    = stl;
        IMEM_BUSY     = ib;
        BRANCH_TARGET = tgt;
        @(posedge CLK);
        model_edge(tk, vld, stl, ib, tgt);
        exp_q.push_back({m_busy, m_target, CNT_W'(m_count)});
        #1;
        e = exp_q.pop_front();
        compare_outputs(e, tag);
    endtask

    task automatic idle_inputs();
        BRANCH_TAKEN  = 1'b0;
        EX_VALID      = 1'b0;
        PIPE_STALL    = 1'b0;
        IMEM_BUSY     = 1'b0;
        BRANCH_TARGET = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        #12;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        int busy_cycles;
        logic [EXP_W-1:0] e;
        idle_inputs();
        RESET = 1'b0;
        model_reset();
        #3;
        // Asynchronous reset values before any clock edge.
        e = {1'b0, 32'h0, CNT_W'(0)};
        compare_outputs(e, "reset");
        #20;
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        // Simple capture with immediate acceptance.
        step(1, 1, 0, 0, 32'h0000_0100, "cap100");
        check("cap100.tgt_const", PC_TARGET, 32'h0000_0100);
        step(0, 0, 0, 0, 32'h0, "cap100_done");
        check("cap100.cnt_const", 32'(TAKEN_COUNT), 32'd1);

        // Capture then IMEM busy for three cycles.
        step(1, 1, 0, 0, 32'h0000_2000, "cap2000");
        busy_cycles = 1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 32'h0, "wait2000");
            if (PC_SEL) busy_cycles++;
        end
        step(0, 0, 0, 0, 32'h0, "wait2000_done");
        check("wait2000.held_cycles", 32'(busy_cycles), 32'd4);

        // Ignored branches: invalid EX, then stalled.
        step(1, 0, 0, 0, 32'h0000_3000, "ign_invalid");
        step(1, 1, 1, 0, 32'h0000_4000, "ign_stall");
        check("ign.cnt_const", 32'(TAKEN_COUNT), 32'd2);

        // Wrong-path branch during a redirect.
        step(1, 1, 0, 0, 32'h0000_5000, "cap5000");
        step(1, 1, 0, 1, 32'hDEAD_BEEC, "wrongpath");
        step(1, 1, 0, 0, 32'hDEAD_BEEC, "wrongpath_done");
        check("wrongpath.tgt_const", PC_TARGET, 32'h0000_5000);

        // Stall freezes a pending redirect.
        step(1, 1, 0, 0, 32'h0000_6000, "cap6000");
        step(0, 0, 1, 0, 32'h0, "stall_hold0");
        step(0, 0, 1, 1, 32'h0, "stall_hold1");
        step(0, 0, 0, 0, 32'h0, "stall_release");
        // Back-to-back capture right after returning to idle.
        step(1, 1, 0, 0, 32'h0000_7004, "b2b");
        step(0, 0, 0, 0, 32'h0, "b2b_done");

        // Reset pulsed during WAIT_IMEM: outputs clear without a clock edge.
        step(1, 1, 0, 0, 32'h0000_8000, "cap8000");
        step(0, 0, 0, 1, 32'h0, "wait8000");
        #2;
        RESET = 1'b0;
        model_reset();
        #1;
        e = {1'b0, 32'h0, CNT_W'(0)};
        compare_outputs(e, "async_rst");
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        step(0, 0, 0, 1, 32'h0, "post_rst_idle");

        // Saturation: 17 accepted redirects on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(1, 1, 0, 0, 32'($urandom), "sat_cap");
            step(0, 0, 0, 0, 32'h0, "sat_acc");
        end
        check("sat.cnt_const", 32'(TAKEN_COUNT), 32'hF);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0),
                 32'($urandom), "rand");
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
